// File: rtl/motor_bank_driver.sv
// Multi-channel BLDC bridge driver: hall-sensor commutation, shared PWM,
// per-switch dead-time insertion, brake, and latched invalid-hall/stall faults.
module motor_bank_driver #(
    parameter int NUM_MOTORS   = 5,
    parameter int DUTY_WIDTH   = 9,
    parameter int DEAD_TIME    = 2,
    parameter int HALL_TIMEOUT = 1000000
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_MOTORS-1:0]            enable,
    input  logic [NUM_MOTORS-1:0]            dir,
    input  logic [NUM_MOTORS-1:0]            brake,
    input  logic [NUM_MOTORS*DUTY_WIDTH-1:0] duty,
    input  logic [NUM_MOTORS*3-1:0]          hall,
    input  logic [NUM_MOTORS-1:0]            fault_clear,
    output logic [NUM_MOTORS*6-1:0]          phase_outputs,
    output logic [NUM_MOTORS-1:0]            fault
);

    localparam int STALL_W = $clog2(HALL_TIMEOUT + 1);
    localparam logic [STALL_W-1:0]    STALL_MAX = STALL_W'(HALL_TIMEOUT);
    localparam logic [STALL_W-1:0]    STALL_ONE = STALL_W'(1);
    localparam logic [DUTY_WIDTH-1:0] PWM_LAST  = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [DUTY_WIDTH-1:0] PWM_ONE   = DUTY_WIDTH'(1);
    localparam logic [3:0]            DT_CYC    = 4'(DEAD_TIME);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_BRAKE = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Returns {high phase, low phase}, each one-hot as {A,B,C}; zero for 000/111.
    function automatic logic [5:0] commutate(input logic [2:0] h, input logic fwd);
        logic [2:0] hi;
        logic [2:0] lo;
        hi = 3'b000;
        lo = 3'b000;
        case (h)
            3'b101: begin hi = 3'b100; lo = 3'b010; end
            3'b100: begin hi = 3'b100; lo = 3'b001; end
            3'b110: begin hi = 3'b010; lo = 3'b001; end
            3'b010: begin hi = 3'b010; lo = 3'b100; end
            3'b011: begin hi = 3'b001; lo = 3'b100; end
            3'b001: begin hi = 3'b001; lo = 3'b010; end
            default: begin hi = 3'b000; lo = 3'b000; end
        endcase
        return fwd ? {hi, lo} : {lo, hi};
    endfunction

    function automatic logic [5:0] switch_map(input logic [2:0] hi, input logic [2:0] lo,
                                              input logic pwm);
        return {hi[2] & pwm, lo[2], hi[1] & pwm, lo[1], hi[0] & pwm, lo[0]};
    endfunction

    logic [DUTY_WIDTH-1:0] pwm_q, pwm_d;

    assign pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_ONE;

    always_ff @(posedge clock) begin
        if (!reset_n) pwm_q <= '0;
        else          pwm_q <= pwm_d;
    end

    for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_ch
        logic [2:0]            sync1_q, sync2_q, hall_prev_q;
        logic [1:0]            state_q, state_d;
        logic                  bad_q, bad_d;
        logic                  fault_q;
        logic [STALL_W-1:0]    stall_q, stall_d;
        logic [5:0]            out_q, out_d, sw_req;
        logic [3:0]            off_q [6];
        logic [3:0]            off_d [6];
        logic [DUTY_WIDTH-1:0] duty_k;
        logic [5:0]            comm;
        logic                  hall_bad, hall_chg, stall_hit, inv_fault, pwm_on;

        assign duty_k    = duty[k*DUTY_WIDTH +: DUTY_WIDTH];
        assign hall_bad  = (sync2_q == 3'b000) || (sync2_q == 3'b111);
        assign hall_chg  = (sync2_q != hall_prev_q);
        assign pwm_on    = (pwm_q < duty_k);
        assign stall_hit = (state_q == ST_RUN) && (stall_q >= STALL_MAX);
        assign inv_fault = (state_q == ST_RUN) && hall_bad && bad_q;
        assign comm      = commutate(sync2_q, dir[k]);
        assign bad_d     = (state_q == ST_RUN) && hall_bad;

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: begin
                    if (brake[k])       state_d = ST_BRAKE;
                    else if (enable[k]) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stall_hit || inv_fault) state_d = ST_FAULT;
                    else if (brake[k])          state_d = ST_BRAKE;
                    else if (!enable[k])        state_d = ST_IDLE;
                end
                ST_BRAKE: begin
                    if (!brake[k]) state_d = enable[k] ? ST_RUN : ST_IDLE;
                end
                default: begin
                    // A clear coinciding with a still-invalid hall keeps the latch.
                    if (fault_clear[k] && !hall_bad) state_d = ST_IDLE;
                end
            endcase
        end

        always_comb begin
            stall_d = stall_q;
            if ((state_q != ST_RUN) || hall_chg)
                stall_d = '0;
            else if ((duty_k != '0) && (stall_q < STALL_MAX))
                stall_d = stall_q + STALL_ONE;
        end

        // Outputs follow the next state so they switch in step with the FSM.
        always_comb begin
            sw_req = 6'b000000;
            case (state_d)
                ST_RUN:   sw_req = switch_map(comm[5:3], comm[2:0], pwm_on);
                ST_BRAKE: sw_req = 6'b010101;
                default:  sw_req = 6'b000000;
            endcase
        end

        // Bits pair as (2p+1, 2p) = (high, low), so the complement of bit i is i^1.
        always_comb begin
            out_d = 6'b000000;
            for (int i = 0; i < 6; i++) begin
                out_d[i] = sw_req[i] && (off_q[i ^ 1] >= DT_CYC);
                if (out_d[i])              off_d[i] = 4'd0;
                else if (off_q[i] < DT_CYC) off_d[i] = off_q[i] + 4'd1;
                else                       off_d[i] = off_q[i];
            end
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                sync1_q     <= 3'b000;
                sync2_q     <= 3'b000;
                hall_prev_q <= 3'b000;
                state_q     <= ST_IDLE;
                bad_q       <= 1'b0;
                fault_q     <= 1'b0;
                stall_q     <= '0;
                out_q       <= 6'b000000;
                for (int i = 0; i < 6; i++) off_q[i] <= 4'd0;
            end else begin
                sync1_q     <= hall[3*k +: 3];
                sync2_q     <= sync1_q;
                hall_prev_q <= sync2_q;
                state_q     <= state_d;
                bad_q       <= bad_d;
                fault_q     <= (state_d == ST_FAULT);
                stall_q     <= stall_d;
                out_q       <= out_d;
                for (int i = 0; i < 6; i++) off_q[i] <= off_d[i];
            end
        end

        assign phase_outputs[6*k +: 6] = out_q;
        assign fault[k]                = fault_q;
    end

endmodule

// File: tb/tb_motor_bank_driver.sv
// Directed bench for motor_bank_driver: commutation tables, dead-time, brake,
// invalid-hall and stall faults, PWM duty, and reset behaviour.
module tb_motor_bank_driver;

    localparam int NM = 2;
    localparam int DW = 9;
    localparam int DT = 2;
    localparam int HT = 100;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset_n;
    logic [NM-1:0]        enable, dir, brake, fault_clear;
    logic [NM*DW-1:0]     duty;
    logic [NM*3-1:0]      hall;
    logic [NM*6-1:0]      phase_outputs;
    logic [NM-1:0]        fault;

    logic                 pw_enable, pw_dir, pw_brake, pw_fclr;
    logic [DW-1:0]        pw_duty;
    logic [2:0]           pw_hall;
    logic [5:0]           pw_phase;
    logic                 pw_fault;

    motor_bank_driver #(.NUM_MOTORS(NM), .DUTY_WIDTH(DW), .DEAD_TIME(DT), .HALL_TIMEOUT(HT)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .dir(dir), .brake(brake),
        .duty(duty), .hall(hall), .fault_clear(fault_clear),
        .phase_outputs(phase_outputs), .fault(fault)
    );

    // Long stall timeout so a constant hall can be held for a whole PWM period.
    motor_bank_driver #(.NUM_MOTORS(1), .DUTY_WIDTH(DW), .DEAD_TIME(DT), .HALL_TIMEOUT(1000000)) u_pwm (
        .clock(clock), .reset_n(reset_n), .enable(pw_enable), .dir(pw_dir), .brake(pw_brake),
        .duty(pw_duty), .hall(pw_hall), .fault_clear(pw_fclr),
        .phase_outputs(pw_phase), .fault(pw_fault)
    );

    logic [5:0] ch0, ch1;
    assign ch0 = phase_outputs[5:0];
    assign ch1 = phase_outputs[11:6];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Cycle monitor: shoot-through and dead-time on every switch of both instances.
    logic [17:0] mon_cur;
    logic [17:0] prev_o = '0;
    int          run_len [18];
    int          st_viol = 0;
    int          dt_viol = 0;
    assign mon_cur = {pw_phase, phase_outputs};

    function automatic int count_st(input logic [17:0] c);
        int n = 0;
        for (int j = 0; j < 18; j += 2) if (c[j] === 1'b1 && c[j+1] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_dt(input logic [17:0] c);
        int n = 0;
        for (int j = 0; j < 18; j++)
            if (c[j] === 1'b1 && prev_o[j] === 1'b0 && run_len[j ^ 1] < DT) n++;
        return n;
    endfunction

    always @(negedge clock) begin
        st_viol <= st_viol + count_st(mon_cur);
        dt_viol <= dt_viol + count_dt(mon_cur);
        for (int j = 0; j < 18; j++)
            run_len[j] <= (mon_cur[j] === 1'b1) ? 0 : ((run_len[j] < 1000) ? run_len[j] + 1 : run_len[j]);
        prev_o <= mon_cur;
    end

    typedef struct {
        logic [2:0] hall;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl [12];
    vec_t       cur_v;
    logic [5:0] prev_exp;
    int         ah_cnt, bl_bad, c_bad, stall_bad;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {AH,AL,BH,BL,CH,CL}; entries 0..5 forward, 6..11 reverse.
        tbl[0]  = '{hall: 3'b101, exp: 6'b100100};
        tbl[1]  = '{hall: 3'b100, exp: 6'b100001};
        tbl[2]  = '{hall: 3'b110, exp: 6'b001001};
        tbl[3]  = '{hall: 3'b010, exp: 6'b011000};
        tbl[4]  = '{hall: 3'b011, exp: 6'b010010};
        tbl[5]  = '{hall: 3'b001, exp: 6'b000110};
        tbl[6]  = '{hall: 3'b101, exp: 6'b011000};
        tbl[7]  = '{hall: 3'b100, exp: 6'b010010};
        tbl[8]  = '{hall: 3'b110, exp: 6'b000110};
        tbl[9]  = '{hall: 3'b010, exp: 6'b100100};
        tbl[10] = '{hall: 3'b011, exp: 6'b100001};
        tbl[11] = '{hall: 3'b001, exp: 6'b001001};

        reset_n = 1'b0; fault_clear = '0; brake = '0;
        pw_enable = 1'b0; pw_dir = 1'b1; pw_brake = 1'b0; pw_fclr = 1'b0;
        pw_duty = '0; pw_hall = 3'b101;
        // Active inputs while in reset must be ignored.
        enable = 2'b11; dir = 2'b11; duty = '1; hall = {3'b101, 3'b101};
        tick(3);
        check("reset_phase", 32'(phase_outputs), 32'(0));
        check("reset_fault", 32'(fault), 32'(0));
        check("reset_pwm_inst", 32'(pw_phase), 32'(0));
        enable = 2'b00;
        reset_n = 1'b1;
        tick(4);
        check("idle_phase", 32'(phase_outputs), 32'(0));

        // Commutation tables with exact hall-to-output latency.
        enable[0] = 1'b1;
        for (int g = 0; g < 2; g++) begin
            dir[0] = (g == 0);
            hall[2:0] = 3'b001;
            tick(10);
            prev_exp = (g == 0) ? 6'b000110 : 6'b001001;
            check($sformatf("settle_dir%0d", 1 - g), 32'(ch0), 32'(prev_exp));
            for (int v = 0; v < 6; v++) begin
                cur_v = tbl[g*6 + v];
                hall[2:0] = cur_v.hall;
                tick(2);
                check($sformatf("vec%0d_hold", g*6 + v), 32'(ch0), 32'(prev_exp));
                tick(1);
                check($sformatf("vec%0d_edge", g*6 + v), 32'(ch0), 32'(cur_v.exp));
                tick(5);
                prev_exp = cur_v.exp;
            end
        end

        // Direction flip on a fixed hall: two dead cycles, then the new pair.
        dir[0] = 1'b1; hall[2:0] = 3'b101;
        tick(10);
        check("dt_fwd_settle", 32'(ch0), 32'(6'b100100));
        dir[0] = 1'b0;
        tick(1); check("dt_rev_c1", 32'(ch0), 32'(0));
        tick(1); check("dt_rev_c2", 32'(ch0), 32'(0));
        tick(1); check("dt_rev_c3", 32'(ch0), 32'(6'b011000));
        dir[0] = 1'b1;
        tick(1); check("dt_fwd_c1", 32'(ch0), 32'(0));
        tick(1); check("dt_fwd_c2", 32'(ch0), 32'(0));
        tick(1); check("dt_fwd_c3", 32'(ch0), 32'(6'b100100));

        // Brake: ch0 from RUN waits dead-time on AL, ch1 from IDLE brakes at once.
        brake = 2'b11;
        tick(1);
        check("brake_ch0_c1", 32'(ch0), 32'(6'b000101));
        check("brake_ch1_c1", 32'(ch1), 32'(6'b010101));
        tick(2);
        check("brake_ch0_c3", 32'(ch0), 32'(6'b010101));
        brake = 2'b00;
        tick(1);
        check("unbrake_ch0_c1", 32'(ch0), 32'(6'b000100));
        check("unbrake_ch1_idle", 32'(ch1), 32'(0));
        tick(2);
        check("unbrake_ch0_c3", 32'(ch0), 32'(6'b100100));

        // Invalid hall in RUN.
        hall[2:0] = 3'b111;
        tick(3);
        check("inv_not_yet", 32'(fault[0]), 32'(0));
        tick(1);
        check("inv_fault", 32'(fault[0]), 32'(1));
        check("inv_outputs_off", 32'(ch0), 32'(0));
        check("inv_ch1_clean", 32'(fault[1]), 32'(0));
        fault_clear[0] = 1'b1;
        tick(1);
        fault_clear[0] = 1'b0;
        tick(1);
        check("clear_blocked", 32'(fault[0]), 32'(1));
        hall[2:0] = 3'b101;
        tick(4);
        enable[0] = 1'b0;
        fault_clear[0] = 1'b1;
        tick(1);
        fault_clear[0] = 1'b0;
        check("clear_ok", 32'(fault[0]), 32'(0));

        // PWM: duty 128 over one full 511-cycle period.
        pw_enable = 1'b1; pw_duty = 9'd128;
        tick(20);
        ah_cnt = 0; bl_bad = 0; c_bad = 0;
        for (int t = 0; t < 511; t++) begin
            tick(1);
            if (pw_phase[5]) ah_cnt++;
            if (!pw_phase[2]) bl_bad++;
            if (pw_phase[1:0] != 2'b00) c_bad++;
        end
        check("pwm_ah_count", 32'(ah_cnt), 32'(128));
        check("pwm_bl_gaps", 32'(bl_bad), 32'(0));
        check("pwm_c_active", 32'(c_bad), 32'(0));

        // Reset mid-PWM and from FAULT.
        enable[0] = 1'b1; hall[2:0] = 3'b111;
        tick(6);
        check("pre_reset_fault", 32'(fault[0]), 32'(1));
        check("pre_reset_pwm_bl", 32'(pw_phase[2]), 32'(1));
        reset_n = 1'b0;
        tick(1);
        check("midrst_phase", 32'(phase_outputs), 32'(0));
        check("midrst_fault", 32'(fault), 32'(0));
        check("midrst_pwm_phase", 32'(pw_phase), 32'(0));
        check("midrst_pwm_fault", 32'(pw_fault), 32'(0));
        enable[0] = 1'b0; hall[2:0] = 3'b101; pw_enable = 1'b0; brake[1] = 1'b1;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        check("post_rst_dead", 32'(ch1), 32'(0));
        tick(1);
        check("post_rst_brake", 32'(ch1), 32'(6'b010101));
        brake[1] = 1'b0;
        tick(2);

        // Stall with a constant hall.
        duty[8:0] = 9'd50;
        enable[0] = 1'b1;
        tick(99);
        check("stall_early", 32'(fault[0]), 32'(0));
        tick(3);
        check("stall_trip", 32'(fault[0]), 32'(1));
        enable[0] = 1'b0;
        fault_clear[0] = 1'b1;
        tick(1);
        fault_clear[0] = 1'b0;
        check("stall_clear", 32'(fault[0]), 32'(0));

        // Hall toggling every 99 cycles never stalls.
        stall_bad = 0;
        for (int t = 0; t < 6; t++) begin
            hall[2:0] = (t % 2 == 0) ? 3'b100 : 3'b101;
            if (t == 0) enable[0] = 1'b1;
            for (int c = 0; c < 99; c++) begin
                tick(1);
                if (fault[0]) stall_bad++;
            end
        end
        check("toggle_no_stall", 32'(stall_bad), 32'(0));

        // Duty 0: high side never on and the stall counter does not advance.
        duty[8:0] = 9'd0;
        tick(150);
        check("duty0_no_stall", 32'(fault[0]), 32'(0));
        check("duty0_outputs", 32'(ch0), 32'(6'b000100));

        check("shoot_through", 32'(st_viol), 32'(0));
        check("dead_time", 32'(dt_viol), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_bank_driver.md
MOTOR_BANK_DRIVER -- requirements
Module: motor_bank_driver

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter NUM_MOTORS, default 5, SHALL set the number of independent BLDC channels.
REQ-003 Parameter DUTY_WIDTH, default 9, SHALL set the duty-command width per channel.
REQ-004 Parameter DEAD_TIME, default 2, SHALL set the minimum off-cycles before either switch of a phase turns on; legal range 1..15.
REQ-005 Parameter HALL_TIMEOUT, default 1000000, SHALL set the stall-detect limit in clock cycles.
REQ-006 clock  in  1  system clock; all logic on rising edge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 enable  in  NUM_MOTORS  per-channel run request.
REQ-009 dir  in  NUM_MOTORS  per-channel direction: 1 = forward, 0 = reverse.
REQ-010 brake  in  NUM_MOTORS  per-channel brake request.
REQ-011 duty  in  NUM_MOTORS*DUTY_WIDTH  per-channel duty; channel k occupies bits [k*DUTY_WIDTH +: DUTY_WIDTH].
REQ-012 hall  in  NUM_MOTORS*3  asynchronous hall inputs; channel k = bits [3k+2:3k] = {Ha,Hb,Hc}.
REQ-013 fault_clear  in  NUM_MOTORS  per-channel fault-clear pulse.
REQ-014 phase_outputs  out  NUM_MOTORS*6  channel k = bits [6k+5:6k] = {AH,AL,BH,BL,CH,CL}; registered.
REQ-015 fault  out  NUM_MOTORS  per-channel latched fault; registered.

Function
REQ-016 A shared PWM counter SHALL count 0..2^DUTY_WIDTH-2 and wrap to 0, giving a period of 2^DUTY_WIDTH-1 cycles.
REQ-017 pwm_on for channel k SHALL be (counter < duty_k): duty 0 = always off; duty all-ones = always on.
REQ-018 Each hall bus SHALL pass through a 2-flop synchroniser; hall-to-commutation latency SHALL be 2 cycles, plus 1 output register.
REQ-019 Forward commutation (hall -> high/low phase) SHALL be: 101 A+/B-, 100 A+/C-, 110 B+/C-, 010 B+/A-, 011 C+/A-, 001 C+/B-; the third phase floats (both switches off).
REQ-020 For reverse, the high and low phase of each row SHALL be swapped.
REQ-021 In RUN, the high-side switch SHALL be gated by pwm_on, and the low-side switch of the low phase SHALL be on continuously.
REQ-022 Per-channel FSM states SHALL be IDLE, RUN, BRAKE, FAULT.
REQ-023 IDLE: all switches off; enter RUN when enable=1 and brake=0; enter BRAKE when brake=1.
REQ-024 RUN: return to IDLE on enable=0; enter BRAKE on brake=1.
REQ-025 BRAKE: AL, BL and CL on, all high sides off; on brake=0, go to RUN if enable=1, else IDLE.
REQ-026 FAULT SHALL be entered from any state on a fault condition; in FAULT all six switches SHALL be off.
REQ-027 Priority SHALL be FAULT > BRAKE > RUN > IDLE.
REQ-028 Invalid-hall fault: synchronised hall = 000 or 111 for 2 consecutive cycles while in RUN.
REQ-029 Stall fault: a per-channel counter SHALL count cycles in RUN with duty != 0 and the synchronised hall unchanged.
REQ-030 The stall counter SHALL reset on any hall change or on leaving RUN, and SHALL signal a fault at HALL_TIMEOUT; the counter saturates.
REQ-031 FAULT SHALL exit to IDLE only on fault_clear=1 with no fault condition present in the same cycle; if both occur in the same cycle, the channel SHALL stay in FAULT.
REQ-032 The fault output SHALL be 1 exactly while the channel is in FAULT.
REQ-033 Dead-time: a switch SHALL turn on only after its complementary switch in the same phase has been off for DEAD_TIME consecutive cycles; until then the request is held off, not dropped.
REQ-034 Turn-off SHALL take effect on the next cycle with no delay.
REQ-035 AH&AL, BH&BL and CH&CL SHALL never be 1 in the same cycle under any input sequence.
REQ-036 Channels SHALL be fully independent except for the shared PWM counter.

Reset
REQ-037 While reset_n=0 at a clock edge: PWM counter=0, synchronisers=000, stall and dead-time counters=0, every FSM=IDLE, phase_outputs=0, fault=0.
REQ-038 Reset asserted mid-operation SHALL force the reset state on the next edge, including from FAULT; inputs are ignored during reset.
REQ-039 After reset release, dead-time counters SHALL start at 0, so the first turn-on occurs no earlier than DEAD_TIME cycles after release.

Verification
REQ-040 Run: enable=1, dir=1, duty=all-ones, hall stepped 101->100->110->010->011->001 -> the six outputs follow REQ-019, with the first change 3 cycles after each hall edge.
REQ-041 PWM: duty=128, DUTY_WIDTH=9, hall=101 -> AH high 128 of every 511 cycles, BL constantly 1, C phase 0.
REQ-042 Dead-time: flip dir on a fixed hall with DEAD_TIME=2 -> every newly-on switch appears 2 or more cycles after its complement falls; no shoot-through in any cycle.
REQ-043 Fault: hall=111 in RUN for 2 cycles -> fault=1 and outputs=0; fault_clear with hall still 111 -> stays FAULT; hall=101, then fault_clear -> IDLE, fault=0.
REQ-044 Stall: HALL_TIMEOUT=100, duty=50, constant hall -> fault asserts after 100 RUN cycles; toggling the hall every 99 cycles -> no fault.
REQ-045 Brake/reset: brake=1 during RUN -> AL=BL=CL=1 after dead-time; reset_n=0 mid-PWM -> all outputs and fault are 0 on the next edge.
